serial_alu_seq: RTL

Bit-serial N-bit ALU sequencer: the control side that drives a 1-bit ALU slice. It accepts two operands and a 4-bit ALU control word through a valid/ready handshake. It then steps the slice LSB-first for WIDTH cycles, chaining the carry through a flop, and returns the result plus flags on a second valid/ready handshake. It replaces a WIDTH-slice ripple array wherever area matters more than latency.

---
 rtl/serial_alu_pkg.sv | 17 +
 rtl/serial_alu_slice.sv | 35 +++
 rtl/serial_alu_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU: control words, slice op field and sequencer states.
package serial_alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice with optional operand inversion; op 2'b11 yields zero.
module serial_alu_slice
  import serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic [1:0] op,
  output logic       result,
  output logic       cout
);

  logic aa;
  logic bb;

  always_comb begin
    aa     = a ^ ainvert;
    bb     = b ^ binvert;
    result = 1'b0;
    cout   = 1'b0;
    case (op)
      OP_AND: result = aa & bb;
      OP_OR:  result = aa | bb;
      OP_ADD: begin
        result = aa ^ bb ^ cin;
        cout   = (aa & bb) | (cin & (aa ^ bb));
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: steps one slice LSB-first over WIDTH cycles and reports result/flags.
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [3:0]       ctrl;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       slice_op;
  logic             slice_res;
  logic             slice_cout;
  logic [WIDTH-1:0] full_res;
  logic [WIDTH-1:0] fin_res;
  logic             fin_carry;
  logic             fin_ovf;
  logic             fin_err;
  logic             ovf_raw;

  // SLT shares the subtract datapath; only the final result is reshaped.
  assign slice_op = (ctrl == CTRL_SLT) ? OP_ADD : ctrl[1:0];

  serial_alu_slice u_slice (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .cin     (carry),
    .ainvert (ctrl[3]),
    .binvert (ctrl[2]),
    .op      (slice_op),
    .result  (slice_res),
    .cout    (slice_cout)
  );

  // Flag finalisation, only meaningful on the MSB step where carry holds carry-into-MSB.
  always_comb begin
    full_res  = {slice_res, res_sh};
    ovf_raw   = carry ^ slice_cout;
    fin_res   = full_res;
    fin_carry = 1'b0;
    fin_ovf   = 1'b0;
    fin_err   = 1'b0;
    case (ctrl)
      CTRL_AND, CTRL_OR, CTRL_NOR: begin
      end
      CTRL_ADD, CTRL_SUB: begin
        fin_carry = slice_cout;
        fin_ovf   = ovf_raw;
      end
      CTRL_SLT: fin_res = {{(WIDTH - 1){1'b0}}, slice_res ^ ovf_raw};
      default: begin
        fin_res = '0;
        fin_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      ctrl       <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh     <= in_a;
            b_sh     <= in_b;
            ctrl     <= in_ctrl;
            carry    <= in_ctrl[2];
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= full_res[WIDTH-1:1];
          carry  <= slice_cout;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            out_result <= fin_res;
            out_carry  <= fin_carry;
            out_zero   <= (fin_res == '0);
            out_ovf    <= fin_ovf;
            out_err    <= fin_err;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
